// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter feeding one UART transmitter
module uart_tx_arbiter #(
  parameter int FRAME_BITS   = 8,
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 8,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*FRAME_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_status,
  output logic                          tx_start,
  output logic [FRAME_BITS-1:0]         tx_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          grant_valid,
  output logic                          err_timeout
);

  localparam int GW   = $clog2(NUM_REQ);
  localparam int TMAX = (BUSY_TIMEOUT > HOLD_TIMEOUT) ? BUSY_TIMEOUT : HOLD_TIMEOUT;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] BUSY_LIM  = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LIM  = CW'(HOLD_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [GW-1:0] LAST_INIT = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [CW-1:0]         w_cnt_inc;
  logic [GW-1:0]         r_last_grant;
  logic [GW-1:0]         w_last_grant_nxt;
  logic                  r_last;
  logic                  w_last_nxt;

  logic                  r_tx_start;
  logic                  w_tx_start_nxt;
  logic [FRAME_BITS-1:0] r_tx_data;
  logic [FRAME_BITS-1:0] w_tx_data_nxt;
  logic [NUM_REQ-1:0]    r_req_ready;
  logic [NUM_REQ-1:0]    w_req_ready_nxt;
  logic [GW-1:0]         r_grant_id;
  logic [GW-1:0]         w_grant_id_nxt;
  logic                  r_grant_valid;
  logic                  w_grant_valid_nxt;
  logic                  r_err_timeout;
  logic                  w_err_timeout_nxt;

  logic                  w_rr_found;
  logic [GW-1:0]         w_rr_id;
  int                    w_dist;
  int                    w_best;

  logic [GW-1:0]         w_src_id;
  logic                  w_src_valid;
  logic                  w_src_last;
  logic [FRAME_BITS-1:0] w_src_data;
  logic [NUM_REQ-1:0]    w_src_onehot;

  // Round-robin winner: the valid requester closest after last_grant, wrapping.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_id    = '0;
    w_dist     = 0;
    w_best     = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = (i + NUM_REQ - 1 - int'(r_last_grant)) % NUM_REQ;
      if (req_valid[i] && (w_dist < w_best)) begin
        w_best     = w_dist;
        w_rr_id    = GW'(i);
        w_rr_found = 1'b1;
      end
    end
  end

  // In IDLE the round-robin winner is the source; otherwise only the locked holder.
  assign w_src_id = (r_state == IDLE) ? w_rr_id : r_grant_id;

  // Select the source requester's valid, last flag, byte and ready bit.
  always_comb begin
    w_src_valid  = 1'b0;
    w_src_last   = 1'b0;
    w_src_data   = '0;
    w_src_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == w_src_id) begin
        w_src_valid     = req_valid[i];
        w_src_last      = req_last[i];
        w_src_data      = req_data[i*FRAME_BITS +: FRAME_BITS];
        w_src_onehot[i] = 1'b1;
      end
    end
  end

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

  // Next-state and next-output logic; pulses default low, grant fields hold.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = w_cnt_inc;
    w_last_grant_nxt  = r_last_grant;
    w_last_nxt        = r_last;
    w_tx_start_nxt    = 1'b0;
    w_tx_data_nxt     = r_tx_data;
    w_req_ready_nxt   = '0;
    w_grant_id_nxt    = r_grant_id;
    w_grant_valid_nxt = r_grant_valid;
    w_err_timeout_nxt = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_rr_found && !tx_status) begin
          w_tx_start_nxt    = 1'b1;
          w_tx_data_nxt     = w_src_data;
          w_req_ready_nxt   = w_src_onehot;
          w_grant_id_nxt    = w_src_id;
          w_grant_valid_nxt = 1'b1;
          w_last_nxt        = w_src_last;
          w_state_nxt       = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_status) begin
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT_DONE;
        end else if (r_cnt >= BUSY_LIM) begin
          w_cnt_nxt         = '0;
          w_err_timeout_nxt = 1'b1;
          w_last_grant_nxt  = r_grant_id;
          w_grant_valid_nxt = 1'b0;
          w_state_nxt       = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_status) begin
          w_cnt_nxt = '0;
          if (r_last) begin
            w_last_grant_nxt  = r_grant_id;
            w_grant_valid_nxt = 1'b0;
            w_state_nxt       = IDLE;
          end else begin
            w_state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (w_src_valid && !tx_status) begin
          w_cnt_nxt       = '0;
          w_tx_start_nxt  = 1'b1;
          w_tx_data_nxt   = w_src_data;
          w_req_ready_nxt = w_src_onehot;
          w_last_nxt      = w_src_last;
          w_state_nxt     = WAIT_BUSY;
        end else if (r_cnt >= HOLD_LIM) begin
          w_cnt_nxt         = '0;
          w_err_timeout_nxt = 1'b1;
          w_last_grant_nxt  = r_grant_id;
          w_grant_valid_nxt = 1'b0;
          w_state_nxt       = IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_last_grant  <= LAST_INIT;
      r_last        <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_req_ready   <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_last        <= w_last_nxt;
      r_tx_start    <= w_tx_start_nxt;
      r_tx_data     <= w_tx_data_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_err_timeout <= w_err_timeout_nxt;
    end
  end

  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign req_ready   = r_req_ready;
  assign grant_id    = r_grant_id;
  assign grant_valid = r_grant_valid;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int FB = 8;
  localparam int NR = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [NR-1:0]  req_valid = '0;
  logic [NR-1:0]  req_last = '0;
  logic [NR*FB-1:0] req_data = '0;
  logic [NR-1:0]  req_ready;
  logic           tx_status = 1'b0;
  logic           tx_start;
  logic [FB-1:0]  tx_data;
  logic [1:0]     grant_id;
  logic           grant_valid;
  logic           err_timeout;

  uart_tx_arbiter #(
    .FRAME_BITS(FB), .NUM_REQ(NR), .BUSY_TIMEOUT(8), .HOLD_TIMEOUT(1024)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .tx_status(tx_status), .tx_start(tx_start),
    .tx_data(tx_data), .grant_id(grant_id), .grant_valid(grant_valid),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int viol = 0;

  // requester byte queues {last, data}
  logic [8:0] rmem [NR][32];
  logic [4:0] rhead [NR] = '{default: '0};
  logic [4:0] rtail [NR];

  // transmitter model controls and state
  int tx_en = 1;
  int busy_dly = 2;
  int busy_len = 4;
  int dly_cnt = 0;
  int busy_cnt = 0;
  int n_busy = 0;
  int fall_cyc = 0;
  int gv_fall_cyc = 0;

  // event logs
  logic [1:0] log_id [64];
  logic [7:0] log_data [64];
  int         log_cyc [64];
  int         n_start = 0;
  int         err_cyc [16];
  int         n_err = 0;

  logic prev_start = 1'b0;
  logic prev_ready = 1'b0;
  logic prev_err = 1'b0;
  logic prev_gv = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  // negedge: protocol monitor, transmitter model, requester drivers
  always @(negedge clk) begin
    if (reset) begin
      dly_cnt = 0;
      busy_cnt = 0;
      tx_status = 1'b0;
    end else begin
      if (tx_start && prev_start) viol++;
      if ((|req_ready) && prev_ready) viol++;
      if (err_timeout && prev_err) viol++;
      if ((tx_start || (|req_ready)) && tx_status) viol++;
      if (tx_start && (req_ready != (4'b0001 << grant_id))) viol++;
      if (tx_start) begin
        if (n_start < 64) begin
          log_id[n_start] = grant_id;
          log_data[n_start] = tx_data;
          log_cyc[n_start] = cyc;
        end
        n_start++;
      end
      if (err_timeout) begin
        if (n_err < 16) err_cyc[n_err] = cyc;
        n_err++;
      end
      if (prev_gv && !grant_valid) gv_fall_cyc = cyc;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          tx_status = 1'b0;
          fall_cyc = cyc;
        end
      end
      if (dly_cnt > 0) begin
        dly_cnt--;
        if (dly_cnt == 0) begin
          tx_status = 1'b1;
          busy_cnt = busy_len;
          n_busy++;
        end
      end
      if (tx_start && (tx_en != 0)) dly_cnt = busy_dly;
    end
    prev_start = tx_start;
    prev_ready = |req_ready;
    prev_err = err_timeout;
    prev_gv = grant_valid;
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i] && (rhead[i] != rtail[i])) rhead[i] = rhead[i] + 5'd1;
      req_valid[i] = (rhead[i] != rtail[i]);
      req_last[i] = rmem[i][rhead[i]][8];
      req_data[i*FB +: FB] = rmem[i][rhead[i]][7:0];
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    rmem[r][rtail[r]] = {l, d};
    rtail[r] = rtail[r] + 5'd1;
  endtask

  task automatic flush();
    for (int i = 0; i < NR; i++) rtail[i] = rhead[i];
  endtask

  task automatic wait_start(input string name, input int bound);
    int k;
    k = 0;
    while (!tx_start && k < bound) begin step(); k++; end
    chk(name, tx_start, 1);
  endtask

  task automatic wait_idle(input string name, input int bound);
    int k;
    k = 0;
    while (grant_valid && k < bound) begin step(); k++; end
    chk(name, grant_valid, 0);
  endtask

  task automatic tb_reset();
    reset = 1'b1;
    flush();
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  typedef struct {
    logic [3:0] mask;
    logic [1:0] exp_id;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int base;
    int ebase;
    int bbase;
    int k;
    logic [1:0] exp_b [5];
    logic [7:0] exp_d;

    reset = 1'b1;
    for (int i = 0; i < NR; i++) rtail[i] = '0;

    // reset state
    step();
    step();
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_err", err_timeout, 0);
    reset = 1'b0;
    step();

    // single-byte packets; last_grant starts at 3
    tbl[0] = '{4'b0001, 2'd0};
    tbl[1] = '{4'b1111, 2'd1};
    tbl[2] = '{4'b1101, 2'd2};
    tbl[3] = '{4'b1001, 2'd3};
    tbl[4] = '{4'b0110, 2'd1};
    tbl[5] = '{4'b0001, 2'd0};
    tbl[6] = '{4'b0001, 2'd0};
    tbl[7] = '{4'b1010, 2'd1};
    tbl[8] = '{4'b0100, 2'd2};
    tbl[9] = '{4'b1011, 2'd3};
    for (int e = 0; e < 10; e++) begin
      for (int i = 0; i < NR; i++)
        if (tbl[e].mask[i]) push(i, 8'((e << 4) | i), 1'b1);
      wait_start($sformatf("tbl%0d_start", e), 50);
      exp_d = 8'((e << 4) | int'(tbl[e].exp_id));
      chk($sformatf("tbl%0d_grant_id", e), grant_id, tbl[e].exp_id);
      chk($sformatf("tbl%0d_tx_data", e), tx_data, exp_d);
      chk($sformatf("tbl%0d_req_ready", e), req_ready, 4'b0001 << tbl[e].exp_id);
      chk($sformatf("tbl%0d_grant_valid", e), grant_valid, 1);
      flush();
      wait_idle($sformatf("tbl%0d_release", e), 100);
      step();
    end

    // one packet with a long busy period
    tb_reset();
    busy_len = 160;
    base = n_start;
    push(0, 8'h41, 1'b1);
    wait_start("one_start", 50);
    chk("one_data", tx_data, 8'h41);
    chk("one_ready", req_ready, 4'b0001);
    for (int i = 0; i < 50; i++) step();
    chk("one_busy_gv", {tx_status, grant_valid}, 2'b11);
    wait_idle("one_release", 300);
    chk("one_gv_after_fall", gv_fall_cyc - fall_cyc, 1);
    step();
    step();
    chk("one_count", n_start - base, 1);

    // all four continuously valid with last=1
    tb_reset();
    busy_len = 3;
    base = n_start;
    bbase = n_busy;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 4; j++) push(i, 8'(8'hB0 + i), 1'b1);
    k = 0;
    while ((n_start - base) < 5 && k < 400) begin step(); k++; end
    flush();
    exp_b = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int j = 0; j < 5; j++) chk($sformatf("rr_order%0d", j), log_id[base+j], exp_b[j]);
    wait_idle("rr_release", 100);
    step();
    chk("rr_starts", n_start - base, 5);
    chk("rr_busy_periods", n_busy - bbase, 5);

    // locked three-byte packet from requester 1, requester 2 waiting
    tb_reset();
    busy_len = 4;
    base = n_start;
    push(1, 8'hA0, 1'b0);
    push(1, 8'hA1, 1'b0);
    push(1, 8'hA2, 1'b1);
    push(2, 8'hB2, 1'b1);
    k = 0;
    while ((n_start - base) < 4 && k < 200) begin step(); k++; end
    chk("pkt_count", (n_start - base) >= 4, 1);
    chk("pkt_id0", log_id[base], 1);
    chk("pkt_id1", log_id[base+1], 1);
    chk("pkt_id2", log_id[base+2], 1);
    chk("pkt_id3", log_id[base+3], 2);
    chk("pkt_d0", log_data[base], 8'hA0);
    chk("pkt_d1", log_data[base+1], 8'hA1);
    chk("pkt_d2", log_data[base+2], 8'hA2);
    chk("pkt_d3", log_data[base+3], 8'hB2);
    wait_idle("pkt_release", 100);

    // transmitter never goes busy
    tb_reset();
    tx_en = 0;
    base = n_start;
    ebase = n_err;
    push(0, 8'h50, 1'b1);
    push(1, 8'h51, 1'b1);
    k = 0;
    while ((n_start - base) < 2 && k < 100) begin step(); k++; end
    chk("bto_count", (n_start - base) >= 2, 1);
    chk("bto_err_seen", (n_err - ebase) >= 1, 1);
    chk("bto_id0", log_id[base], 0);
    chk("bto_id1", log_id[base+1], 1);
    chk("bto_err_delay", err_cyc[ebase] - log_cyc[base], 8);
    chk("bto_regrant", log_cyc[base+1] - err_cyc[ebase], 1);
    wait_idle("bto_release", 50);
    tx_en = 1;
    step();

    // holder stalls after a non-last byte
    tb_reset();
    busy_len = 4;
    base = n_start;
    ebase = n_err;
    push(3, 8'h33, 1'b0);
    wait_start("hto_start", 50);
    chk("hto_id", grant_id, 3);
    step();
    push(0, 8'h30, 1'b1);
    for (int i = 0; i < 500; i++) step();
    chk("hto_locked", {grant_valid, grant_id, 1'b0}, {1'b1, 2'd3, 1'b0});
    k = 0;
    while ((n_err - ebase) < 1 && k < 1200) begin step(); k++; end
    chk("hto_err_seen", (n_err - ebase) >= 1, 1);
    chk("hto_err_delay", err_cyc[ebase] - fall_cyc, 1025);
    chk("hto_no_start", n_start - base, 1);
    k = 0;
    while ((n_start - base) < 2 && k < 20) begin step(); k++; end
    chk("hto_next_id", log_id[base+1], 0);
    chk("hto_next_cyc", log_cyc[base+1] - err_cyc[ebase], 1);
    wait_idle("hto_release", 100);

    // reset while waiting for the transmitter to finish
    tb_reset();
    busy_len = 40;
    push(2, 8'h22, 1'b0);
    wait_start("rmid_start", 50);
    k = 0;
    while (!tx_status && k < 10) begin step(); k++; end
    step();
    step();
    step();
    chk("rmid_in_busy", {tx_status, grant_valid}, 2'b11);
    reset = 1'b1;
    step();
    chk("rmid_tx_start", tx_start, 0);
    chk("rmid_tx_data", tx_data, 0);
    chk("rmid_req_ready", req_ready, 0);
    chk("rmid_grant_id", grant_id, 0);
    chk("rmid_grant_valid", grant_valid, 0);
    chk("rmid_err", err_timeout, 0);
    reset = 1'b0;
    push(3, 8'h3F, 1'b1);
    push(0, 8'h0F, 1'b1);
    wait_start("rmid_post_start", 50);
    chk("rmid_post_id", grant_id, 0);
    chk("rmid_post_data", tx_data, 8'h0F);
    flush();
    wait_idle("rmid_post_release", 100);

    chk("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
